hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard control for a five-stage pipeline: tracks the producers sitting in E, M and W,
// stalls the D instruction while a needed result is not yet available, and selects the
// forwarding source for the operands consumed in D, E and M.
module hazard_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic [1:0] tuse_rs,
   input  logic [1:0] tuse_rt,
   input  logic [4:0] a3_d,
   input  logic [1:0] tnew_d,
   input  logic       md_use_d,
   input  logic       md_start_e,
   input  logic       md_busy,
   output logic       stall,
   output logic       flush_e,
   output logic [1:0] fwd_rs_d,
   output logic [1:0] fwd_rt_d,
   output logic [1:0] fwd_rs_e,
   output logic [1:0] fwd_rt_e,
   output logic       fwd_rt_m
);

   // E record
   logic [4:0] e_a3_q, e_a3_d;
   logic [1:0] e_tnew_q, e_tnew_d;
   logic [4:0] e_rs_q, e_rs_d;
   logic [4:0] e_rt_q, e_rt_d;
   // M record; its rs field is never consulted, so it is not kept
   logic [4:0] m_a3_q, m_a3_d;
   logic [1:0] m_tnew_q, m_tnew_d;
   logic [4:0] m_rt_q, m_rt_d;
   // W record
   logic [4:0] w_a3_q, w_a3_d;

   logic stall_hz;

   // Register 0 is hard-wired, so it never matches a producer.
   function automatic logic hit(input logic [4:0] a3, input logic [4:0] r);
      return (r != 5'd0) && (a3 == r);
   endfunction

   // D-stage source: nearest matching producer wins; a not-yet-ready one blocks older stages.
   function automatic logic [1:0] sel_d(input logic [4:0] r,
                                        input logic [4:0] ea3, input logic [1:0] etn,
                                        input logic [4:0] ma3, input logic [1:0] mtn,
                                        input logic [4:0] wa3);
      if (hit(ea3, r))      return (etn == 2'd0) ? 2'd1 : 2'd0;
      else if (hit(ma3, r)) return (mtn == 2'd0) ? 2'd2 : 2'd0;
      else if (hit(wa3, r)) return 2'd3;
      else                  return 2'd0;
   endfunction

   // E-stage source: M first, then W, with the same blocking rule.
   function automatic logic [1:0] sel_e(input logic [4:0] r,
                                        input logic [4:0] ma3, input logic [1:0] mtn,
                                        input logic [4:0] wa3);
      if (hit(ma3, r))      return (mtn == 2'd0) ? 2'd1 : 2'd0;
      else if (hit(wa3, r)) return 2'd2;
      else                  return 2'd0;
   endfunction

   // Hazard detection and forwarding selects, purely from inputs and current records
   always_comb begin
      stall_hz = (hit(e_a3_q, rs_d) && (tuse_rs < e_tnew_q)) ||
                 (hit(m_a3_q, rs_d) && (tuse_rs < m_tnew_q)) ||
                 (hit(e_a3_q, rt_d) && (tuse_rt < e_tnew_q)) ||
                 (hit(m_a3_q, rt_d) && (tuse_rt < m_tnew_q));
      stall    = stall_hz || (md_use_d && (md_busy || md_start_e));
      flush_e  = stall;
      fwd_rs_d = sel_d(rs_d, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
      fwd_rt_d = sel_d(rt_d, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
      fwd_rs_e = sel_e(e_rs_q, m_a3_q, m_tnew_q, w_a3_q);
      fwd_rt_e = sel_e(e_rt_q, m_a3_q, m_tnew_q, w_a3_q);
      fwd_rt_m = hit(w_a3_q, m_rt_q);
   end

   // Next records: a stalled D instruction leaves a bubble in E; tnew counts down to 0
   always_comb begin
      e_a3_d   = a3_d;
      e_tnew_d = tnew_d;
      e_rs_d   = rs_d;
      e_rt_d   = rt_d;
      if (stall) begin
         e_a3_d   = 5'd0;
         e_tnew_d = 2'd0;
         e_rs_d   = 5'd0;
         e_rt_d   = 5'd0;
      end
      m_a3_d   = e_a3_q;
      m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
      m_rt_d   = e_rt_q;
      w_a3_d   = m_a3_q;
   end

   // Stage record registers; reset drops every in-flight producer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_a3_q   <= 5'd0;
         e_tnew_q <= 2'd0;
         e_rs_q   <= 5'd0;
         e_rt_q   <= 5'd0;
         m_a3_q   <= 5'd0;
         m_tnew_q <= 2'd0;
         m_rt_q   <= 5'd0;
         w_a3_q   <= 5'd0;
      end else begin
         e_a3_q   <= e_a3_d;
         e_tnew_q <= e_tnew_d;
         e_rs_q   <= e_rs_d;
         e_rt_q   <= e_rt_d;
         m_a3_q   <= m_a3_d;
         m_tnew_q <= m_tnew_d;
         m_rt_q   <= m_rt_d;
         w_a3_q   <= w_a3_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked against a
// model that keeps a per-cycle log of issued instructions and derives hazards from ages.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_d, rt_d, a3_d;
   logic [1:0] tuse_rs, tuse_rt, tnew_d;
   logic       md_use_d, md_start_e, md_busy;
   logic       stall, flush_e, fwd_rt_m;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic [4:0] a3;
      logic [4:0] rs;
      logic [4:0] rt;
      int         tnew;
   } ins_t;

   typedef struct {
      logic       stall;
      logic [1:0] rs_d;
      logic [1:0] rt_d;
      logic [1:0] rs_e;
      logic [1:0] rt_e;
      logic       rt_m;
   } exp_t;

   // hist[c] = instruction that left D at the end of cycle c (bubble if none)
   ins_t hist [4096];

   hazard_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .rs_d      (rs_d),
      .rt_d      (rt_d),
      .tuse_rs   (tuse_rs),
      .tuse_rt   (tuse_rt),
      .a3_d      (a3_d),
      .tnew_d    (tnew_d),
      .md_use_d  (md_use_d),
      .md_start_e(md_start_e),
      .md_busy   (md_busy),
      .stall     (stall),
      .flush_e   (flush_e),
      .fwd_rs_d  (fwd_rs_d),
      .fwd_rt_d  (fwd_rt_d),
      .fwd_rs_e  (fwd_rs_e),
      .fwd_rt_e  (fwd_rt_e),
      .fwd_rt_m  (fwd_rt_m)
   );

   always #5 clk = ~clk;

   function automatic ins_t bubble();
      ins_t b;
      b.a3 = 5'd0; b.rs = 5'd0; b.rt = 5'd0; b.tnew = 0;
      return b;
   endfunction

   // Instruction issued k cycles ago (k=1 is in E, 2 in M, 3 in W)
   function automatic ins_t get(input int k);
      if (cyc - k < 0) return bubble();
      return hist[(cyc - k) & 4095];
   endfunction

   // Cycles still missing before p's result exists, when p is k cycles past D
   function automatic int left(input ins_t p, input int k);
      int r;
      r = p.tnew - (k - 1);
      if (r < 0) r = 0;
      return r;
   endfunction

   function automatic logic hits(input ins_t p, input logic [4:0] r);
      return (r != 5'd0) && (p.a3 == r);
   endfunction

   function automatic logic d_stall(input logic [4:0] r, input logic [1:0] tuse);
      for (int k = 1; k <= 2; k++)
         if (hits(get(k), r) && (int'(tuse) < left(get(k), k))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [1:0] d_src(input logic [4:0] r);
      for (int k = 1; k <= 3; k++)
         if (hits(get(k), r)) return (left(get(k), k) != 0) ? 2'd0 : 2'(k);
      return 2'd0;
   endfunction

   function automatic logic [1:0] e_src(input logic [4:0] r);
      for (int k = 2; k <= 3; k++)
         if (hits(get(k), r)) return (left(get(k), k) != 0) ? 2'd0 : 2'(k - 1);
      return 2'd0;
   endfunction

   function automatic exp_t model_eval();
      exp_t e;
      ins_t ie, im;
      ie = get(1);
      im = get(2);
      e.stall = d_stall(rs_d, tuse_rs) || d_stall(rt_d, tuse_rt) ||
                (md_use_d && (md_busy || md_start_e));
      e.rs_d  = d_src(rs_d);
      e.rt_d  = d_src(rt_d);
      e.rs_e  = e_src(ie.rs);
      e.rt_e  = e_src(ie.rt);
      e.rt_m  = hits(get(3), im.rt);
      return e;
   endfunction

   // Advance one clock and log what left D (nothing while stalled or in reset)
   task automatic tick();
      exp_t e;
      ins_t n;
      e = model_eval();
      @(posedge clk);
      if (!reset || e.stall) n = bubble();
      else begin
         n.a3 = a3_d; n.rs = rs_d; n.rt = rt_d; n.tnew = int'(tnew_d);
      end
      hist[cyc & 4095] = n;
      cyc++;
      #1;
   endtask

   task automatic model_reset();
      for (int k = 1; k <= 3; k++)
         if (cyc - k >= 0) hist[(cyc - k) & 4095] = bubble();
   endtask

   task automatic set_d(input logic [4:0] a3, input logic [1:0] tn,
                        input logic [4:0] rs, input logic [1:0] urs,
                        input logic [4:0] rt, input logic [1:0] urt);
      a3_d = a3; tnew_d = tn; rs_d = rs; tuse_rs = urs; rt_d = rt; tuse_rt = urt;
      md_use_d = 1'b0; md_start_e = 1'b0; md_busy = 1'b0;
   endtask

   task automatic drain();
      set_d(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_d(5'd3, 2'd2, 5'd7, 2'd0, 5'd9, 2'd0);
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if ({stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 10'd0) begin
            $display("FAIL reset_outputs: got %b want 0",
                     {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m});
            n_errors++;
         end
         tick();
      end
      reset = 1'b1;
      drain();
   endtask

   task automatic test_load_use();
      set_d(5'd8, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0) begin
         $display("FAIL lu_producer_stall: got %b want 0", stall); n_errors++;
      end
      tick();
      set_d(5'd0, 2'd0, 5'd8, 2'd0, 5'd0, 2'd3);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         n_checks++;
         if ({stall, flush_e} !== 2'b11) begin
            $display("FAIL lu_stall_c%0d: got %b want 11", c, {stall, flush_e}); n_errors++;
         end
         tick();
      end
      @(negedge clk);
      n_checks++;
      if ({stall, fwd_rs_d} !== 3'b0_11) begin
         $display("FAIL lu_release: got stall=%b fwd_rs_d=%0d want 0/3", stall, fwd_rs_d);
         n_errors++;
      end
      tick();
      drain();
   endtask

   task automatic test_alu_alu();
      set_d(5'd9, 2'd1, 5'd0, 2'd3, 5'd0, 2'd3);
      tick();
      set_d(5'd0, 2'd0, 5'd9, 2'd1, 5'd9, 2'd1);
      @(negedge clk);
      n_checks++;
      if ({stall, fwd_rs_d, fwd_rt_d} !== 5'b0_00_00) begin
         $display("FAIL alu_d: got stall=%b rs=%0d rt=%0d want 0/0/0", stall, fwd_rs_d, fwd_rt_d);
         n_errors++;
      end
      tick();
      drain_inputs_only();
      @(negedge clk);
      n_checks++;
      if ({fwd_rs_e, fwd_rt_e} !== 4'b01_01) begin
         $display("FAIL alu_e: got rs_e=%0d rt_e=%0d want 1/1", fwd_rs_e, fwd_rt_e);
         n_errors++;
      end
      tick();
      @(negedge clk);
      n_checks++;
      if ({fwd_rt_m, fwd_rs_e} !== 3'b1_00) begin
         $display("FAIL alu_m: got rt_m=%b rs_e=%0d want 1/0", fwd_rt_m, fwd_rs_e);
         n_errors++;
      end
      tick();
      drain();
   endtask

   task automatic drain_inputs_only();
      set_d(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
   endtask

   task automatic test_priority();
      set_d(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
      tick();
      tick();
      set_d(5'd6, 2'd0, 5'd5, 2'd0, 5'd0, 2'd3);
      @(negedge clk);
      n_checks++;
      if ({stall, fwd_rs_d} !== 3'b0_01) begin
         $display("FAIL prio_e_over_m: got stall=%b fwd_rs_d=%0d want 0/1", stall, fwd_rs_d);
         n_errors++;
      end
      tick();
      // E now holds 6, M holds 5, W holds 5
      set_d(5'd0, 2'd0, 5'd5, 2'd0, 5'd6, 2'd0);
      @(negedge clk);
      n_checks++;
      if ({fwd_rs_d, fwd_rt_d} !== 4'b10_01) begin
         $display("FAIL prio_m_over_w: got rs=%0d rt=%0d want 2/1", fwd_rs_d, fwd_rt_d);
         n_errors++;
      end
      tick();
      drain();
   endtask

   task automatic test_reg_zero();
      set_d(5'd0, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
      tick();
      set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
      @(negedge clk);
      n_checks++;
      if ({stall, fwd_rs_d, fwd_rt_d} !== 5'd0) begin
         $display("FAIL reg_zero: got stall=%b rs=%0d want 0/0", stall, fwd_rs_d); n_errors++;
      end
      tick();
      drain();
   endtask

   task automatic test_muldiv();
      set_d(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
      md_use_d = 1'b1;
      md_busy  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if ({stall, flush_e} !== 2'b11) begin
            $display("FAIL md_busy_c%0d: got %b want 11", c, {stall, flush_e}); n_errors++;
         end
         tick();
      end
      md_busy = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({stall, flush_e} !== 2'b00) begin
         $display("FAIL md_release: got %b want 00", {stall, flush_e}); n_errors++;
      end
      md_start_e = 1'b1;
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
         $display("FAIL md_start: got %b want 1", stall); n_errors++;
      end
      md_use_d = 1'b0;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
         $display("FAIL md_start_nouse: got %b want 0", stall); n_errors++;
      end
      tick();
      drain();
   endtask

   task automatic test_reset_mid_stall();
      set_d(5'd8, 2'd2, 5'd0, 2'd3, 5'd0, 2'd3);
      tick();
      set_d(5'd0, 2'd0, 5'd8, 2'd0, 5'd8, 2'd0);
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b1) begin
         $display("FAIL rst_pre_stall: got %b want 1", stall); n_errors++;
      end
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 10'd0) begin
         $display("FAIL rst_immediate: got %b want 0",
                  {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m});
         n_errors++;
      end
      tick();
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({stall, fwd_rs_d, fwd_rt_d} !== 5'd0) begin
         $display("FAIL rst_after_d: got stall=%b rs=%0d rt=%0d want 0", stall, fwd_rs_d,
                  fwd_rt_d);
         n_errors++;
      end
      tick();
      drain_inputs_only();
      @(negedge clk);
      n_checks++;
      if ({fwd_rs_e, fwd_rt_e, fwd_rt_m, fwd_rs_d} !== 7'd0) begin
         $display("FAIL rst_after_e: got rs_e=%0d rt_e=%0d rt_m=%b want 0", fwd_rs_e,
                  fwd_rt_e, fwd_rt_m);
         n_errors++;
      end
      tick();
      drain();
   endtask

   task automatic test_random();
      exp_t e;
      for (int i = 0; i < 1500; i++) begin
         a3_d       = 5'($urandom_range(0, 3));
         tnew_d     = 2'($urandom_range(0, 2));
         rs_d       = 5'($urandom_range(0, 3));
         rt_d       = 5'($urandom_range(0, 3));
         tuse_rs    = 2'($urandom_range(0, 3));
         tuse_rt    = 2'($urandom_range(0, 3));
         md_use_d   = ($urandom_range(0, 3) == 0);
         md_busy    = ($urandom_range(0, 4) == 0);
         md_start_e = ($urandom_range(0, 4) == 0);
         @(negedge clk);
         e = model_eval();
         n_checks++;
         if ({stall, flush_e} !== {e.stall, e.stall}) begin
            $display("FAIL rnd_stall[%0d]: got %b want %b", i, {stall, flush_e},
                     {e.stall, e.stall});
            n_errors++;
         end
         n_checks++;
         if ({fwd_rs_d, fwd_rt_d} !== {e.rs_d, e.rt_d}) begin
            $display("FAIL rnd_fwd_d[%0d]: got %0d/%0d want %0d/%0d", i, fwd_rs_d, fwd_rt_d,
                     e.rs_d, e.rt_d);
            n_errors++;
         end
         n_checks++;
         if ({fwd_rs_e, fwd_rt_e} !== {e.rs_e, e.rt_e}) begin
            $display("FAIL rnd_fwd_e[%0d]: got %0d/%0d want %0d/%0d", i, fwd_rs_e, fwd_rt_e,
                     e.rs_e, e.rt_e);
            n_errors++;
         end
         n_checks++;
         if (fwd_rt_m !== e.rt_m) begin
            $display("FAIL rnd_fwd_m[%0d]: got %b want %b", i, fwd_rt_m, e.rt_m);
            n_errors++;
         end
         tick();
      end
      drain();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) hist[i] = bubble();
      reset = 1'b0;
      set_d(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
      test_reset();
      test_load_use();
      test_alu_alu();
      test_priority();
      test_reg_zero();
      test_muldiv();
      test_reset_mid_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
